// File: rtl/led_flash.sv
// -----------------------------------------------------------------------------
// led_flash
//    Divides the system clock down to a 50%-duty LED blink. It uses two stages.
//    A prescaler produces a one-cycle tick every PRESCALE clocks. A final
//    divider counts those ticks and raises a toggle enable every FINAL_DIVIDE
//    ticks. led_out inverts on each toggle enable.
//    All divided rates are clock enables; nothing is clocked by anything
//    except clk.
//
//    With N = PRESCALE*FINAL_DIVIDE, led_out first rises on the Nth clk edge
//    after reset release. It then toggles every N edges, giving a period of 2N.
//
// Parameters
//    PRESCALE      input clocks per prescaler tick          (1 .. 2^24)
//    FINAL_DIVIDE  prescaler ticks per led_out toggle       (1 .. 2^16)
//
// Ports
//    clk      in   system clock, rising-edge active
//    rst      in   asynchronous reset, active low (deassertion pre-synchronised)
//    led_out  out  LED drive, straight from a flip-flop
// -----------------------------------------------------------------------------
module led_flash #(
   parameter int PRESCALE     = 32000,
   parameter int FINAL_DIVIDE = 500
) (
   input  logic clk,
   input  logic rst,
   output logic led_out
);

   // Out-of-range parameters stop elaboration rather than silently
   // producing a truncated counter.
   if (PRESCALE < 1 || PRESCALE > (1 << 24)) begin : g_bad_prescale
      $error("led_flash: PRESCALE=%0d outside 1..2^24", PRESCALE);
   end
   if (FINAL_DIVIDE < 1 || FINAL_DIVIDE > (1 << 16)) begin : g_bad_final_divide
      $error("led_flash: FINAL_DIVIDE=%0d outside 1..2^16", FINAL_DIVIDE);
   end

   // A counter must be able to hold its terminal value (N-1). A divide-by-1
   // still keeps a 1-bit counter; that counter simply never leaves 0.
   localparam int PS_W = (PRESCALE     > 1) ? $clog2(PRESCALE)     : 1;
   localparam int FD_W = (FINAL_DIVIDE > 1) ? $clog2(FINAL_DIVIDE) : 1;

   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [FD_W-1:0] FD_LAST = FD_W'(FINAL_DIVIDE - 1);

   logic [PS_W-1:0] ps_cnt_reg;
   logic [PS_W-1:0] ps_cnt_next;
   logic [FD_W-1:0] fd_cnt_reg;
   logic [FD_W-1:0] fd_cnt_next;
   logic            led_reg;
   logic            led_next;
   logic            tick;
   logic            toggle_en;

   // The tick is decoded from the terminal count. It is active during the same
   // cycle that the prescaler wraps, so there is no extra cycle at the boundary.
   assign tick      = (ps_cnt_reg == PS_LAST);
   assign toggle_en = tick && (fd_cnt_reg == FD_LAST);

   always_comb begin
      ps_cnt_next = ps_cnt_reg;
      fd_cnt_next = fd_cnt_reg;
      led_next    = led_reg;

      if (tick) begin
         ps_cnt_next = '0;
      end else begin
         ps_cnt_next = ps_cnt_reg + 1'b1;
      end

      // The final divider only moves on ticks. When both counters wrap on the
      // same edge, this branch is exactly where that happens.
      if (tick) begin
         if (fd_cnt_reg == FD_LAST) begin
            fd_cnt_next = '0;
         end else begin
            fd_cnt_next = fd_cnt_reg + 1'b1;
         end
      end

      if (toggle_en) begin
         led_next = ~led_reg;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps_cnt_reg <= '0;
         fd_cnt_reg <= '0;
         led_reg    <= 1'b0;
      end else begin
         ps_cnt_reg <= ps_cnt_next;
         fd_cnt_reg <= fd_cnt_next;
         led_reg    <= led_next;
      end
   end

   assign led_out = led_reg;

endmodule

// File: tb/tb_led_flash.sv
// -----------------------------------------------------------------------------
// tb_led_flash
//    Runs four led_flash instances with different divide settings in parallel,
//    all sharing one clock and one reset.
//
//    For each run, the stimulus process picks how many edges to let the
//    design run after reset release. It queues the transitions the design
//    should show in that window. From the rules, these are at edges k*N, and
//    the level after transition k is 1 for odd k and 0 for even k.
//
//    A monitor watches every led_out. On each change, it pops the oldest
//    expected transition and compares the edge number and level.
//
//    At the end of each run, the bench checks that every queue has drained.
//    It then asserts reset between clock edges and checks that all outputs
//    drop to 0 at once.
// -----------------------------------------------------------------------------
module tb_led_flash;

   localparam int NDUT = 4;
   localparam int PS_TAB [NDUT] = '{4, 1, 3, 2};
   localparam int FD_TAB [NDUT] = '{3, 1, 1, 5};

   typedef struct {
      int edge_no;
      bit level;
   } exp_t;

   logic            clk;
   logic            rst;
   logic [NDUT-1:0] leds;

   exp_t exp_q [NDUT][$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   logic [NDUT-1:0] prev = '0;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      led_flash #(
         .PRESCALE    (PS_TAB[gi]),
         .FINAL_DIVIDE(FD_TAB[gi])
      ) u_dut (
         .clk    (clk),
         .rst    (rst),
         .led_out(leds[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: it samples 1 time unit after each rising edge.
   // The stimulus process only moves rst 3..7 units after an edge, so rst is
   // stable at the time the monitor samples it.
   always @(posedge clk) begin
      #1;
      if (rst !== 1'b1) begin
         edge_cnt = 0;
         for (int i = 0; i < NDUT; i++) begin
            prev[i] = 1'b0;
            checks++;
            if (leds[i] !== 1'b0) begin
               errors++;
               $display("FAIL in_reset dut%0d: led_out=%b, required 0", i, leds[i]);
            end
         end
      end else begin
         edge_cnt++;
         for (int i = 0; i < NDUT; i++) begin
            if (leds[i] !== prev[i]) begin
               checks++;
               if ($isunknown(leds[i])) begin
                  errors++;
                  $display("FAIL led_unknown dut%0d edge %0d: led_out=%b, required 0/1",
                           i, edge_cnt, leds[i]);
               end else if (exp_q[i].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_toggle dut%0d: led_out->%b at edge %0d, required no change",
                           i, leds[i], edge_cnt);
               end else begin
                  exp_t e;
                  e = exp_q[i].pop_front();
                  if (e.edge_no != edge_cnt || e.level != leds[i]) begin
                     errors++;
                     $display("FAIL toggle dut%0d: got level %b at edge %0d, required level %b at edge %0d",
                              i, leds[i], edge_cnt, e.level, e.edge_no);
                  end else begin
                     $display("dut%0d toggle -> %b at edge %0d ok", i, leds[i], edge_cnt);
                  end
               end
               prev[i] = leds[i];
            end
         end
      end
   end

   // One run: queue the expected transitions, release reset, run `len` edges,
   // check that the queues have drained, then assert reset between edges.
   task automatic run_trial(input int len);
      for (int i = 0; i < NDUT; i++) begin
         int n;
         n = PS_TAB[i] * FD_TAB[i];
         for (int k = 1; k * n <= len; k++) begin
            exp_t e;
            e.edge_no = k * n;
            e.level   = k[0];
            exp_q[i].push_back(e);
         end
      end
      rst = 1'b1;
      repeat (len) @(posedge clk);
      #2;
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (exp_q[i].size() != 0) begin
            errors++;
            $display("FAIL missing_toggle dut%0d run len %0d: %0d transitions outstanding, required 0",
                     i, len, exp_q[i].size());
            exp_q[i].delete();
         end
      end
      #($urandom_range(1, 5));
      rst = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         checks++;
         if (leds[i] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset dut%0d: led_out=%b, required 0", i, leds[i]);
         end
      end
      $display("run len %0d done, async reset applied", len);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #3;
   endtask

   initial begin
      // Reset is held low from time 0, before the first clock edge, so no
      // output is ever sampled as X.
      rst = 1'b0;
      #100;
      run_trial(40);   // (4,3): rises at 12, falls at 24, rises at 36
      run_trial(18);   // (4,3): reset arrives after edge 18 while led_out is high
      run_trial(12);   // restart after that reset: first rise again at edge 12
      for (int t = 0; t < 20; t++) begin
         run_trial($urandom_range(1, 70));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
